param_updown_counter: RTL



---
 rtl/param_updown_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// Parametrised modulo-(MAX_VAL+1) up/down counter with load, clear, one-shot,
// terminal-count pulse and sticky done flag. Optional wrap counter: CNT_WRAP_COUNTER_EN.
`timescale 1ns/1ps
module param_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15,
    parameter int WRAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic             one_shot,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             done
`ifdef CNT_WRAP_COUNTER_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    localparam longint CAP = (64'sd1 <<< WIDTH) - 64'sd1;

    // Reject parameter sets that cannot be represented.
    if (WIDTH < 1) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be >= 1");
    end
    if (MAX_VAL < 1 || longint'(MAX_VAL) > CAP) begin : g_bad_max
        $error("param_updown_counter: MAX_VAL out of range 1..2^WIDTH-1");
    end
    if (WRAP_W < 1) begin : g_bad_wrap
        $error("param_updown_counter: WRAP_W must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] step_val;
    logic             at_term;
    logic             counting;
    logic             wrap_evt;

    // Direction-dependent terminal, wrap target and single step.
    always_comb begin
        load_sat = (load_val > MAX_V) ? MAX_V : load_val;
        term_val = up_dn ? MAX_V : '0;
        wrap_val = up_dn ? '0 : MAX_V;
        step_val = up_dn ? (cnt_q + WIDTH'(1'b1))
                         : (cnt_q - WIDTH'(1'b1));
        at_term  = (cnt_q == term_val);
        counting = en && !done_q;
        wrap_evt = !clr && !load && counting
                && at_term && !one_shot;
    end

    // Next-state for count, pulse and sticky flag; clr > load > count > hold.
    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (clr) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (load) begin
            cnt_d  = load_sat;
            done_d = 1'b0;
        end else if (counting) begin
            if (at_term) begin
                tc_d = 1'b1;
                if (one_shot) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = wrap_val;
                end
            end else begin
                cnt_d = step_val;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc      = tc_q;
    assign done    = done_q;

`ifdef CNT_WRAP_COUNTER_EN
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    // Saturating count of wrap events; load leaves it untouched.
    always_comb begin
        wrap_d = wrap_q;
        if (clr) begin
            wrap_d = '0;
        end else if (wrap_evt && !(&wrap_q)) begin
            wrap_d = wrap_q + WRAP_W'(1'b1);
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_cnt = wrap_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_evt;
`endif

endmodule
